// File: rtl/led7seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with tear-free double buffering.
// Optional decimal points when LED7SEG_SCAN_DP_EN is defined.
module led7seg_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*N_DIGITS-1:0]   data_in,
  input  logic                    load,
  input  logic [N_DIGITS-1:0]     blank_mask,
  input  logic                    lzb_en,
`ifdef LED7SEG_SCAN_DP_EN
  input  logic [N_DIGITS-1:0]     dp_in,
  output logic                    dp,
`endif
  output logic [6:0]              seg,
  output logic [N_DIGITS-1:0]     an,
  output logic                    upd_pend,
  output logic                    frame_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [N_DIGITS-1:0] AN_OFF =
    AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*N_DIGITS-1:0]   pend_data;
  logic [4*N_DIGITS-1:0]   shad_data;
  logic [N_DIGITS-1:0]     pend_blank;
  logic [N_DIGITS-1:0]     shad_blank;

  logic                    tick;
  logic                    pre_tick;
  logic                    last;
  logic                    wrap;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic                    cur_lz;
  logic                    dark;
  logic [N_DIGITS-1:0]     lz;
  logic [N_DIGITS-1:0]     an_hot;
  logic [6:0]              seg_hi;
  logic [6:0]              seg_pin;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] r;
    unique case (v)
      4'h0: r = 7'h3F;
      4'h1: r = 7'h06;
      4'h2: r = 7'h5B;
      4'h3: r = 7'h4F;
      4'h4: r = 7'h66;
      4'h5: r = 7'h6D;
      4'h6: r = 7'h7D;
      4'h7: r = 7'h07;
      4'h8: r = 7'h7F;
      4'h9: r = 7'h6F;
      4'hA: r = 7'h77;
      4'hB: r = 7'h7C;
      4'hC: r = 7'h39;
      4'hD: r = 7'h5E;
      4'hE: r = 7'h79;
      default: r = 7'h71;
    endcase
    return r;
  endfunction

  assign tick     = (cnt == CW'(CLK_DIV - 1));
  assign pre_tick = (cnt == CW'(CLK_DIV - 2));
  assign last     = (idx == IW'(N_DIGITS - 1));
  assign wrap     = tick & last;

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    logic run;
    lz  = '0;
    run = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      run   = run & (shad_data[4*k +: 4] == 4'h0);
      lz[k] = run;
    end
    lz[0] = 1'b0;
  end

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    an_hot    = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib   = shad_data[4*k +: 4];
        cur_blank = shad_blank[k];
        cur_lz    = lz[k];
        an_hot[k] = 1'b1;
      end
    end
  end

  assign dark    = cur_blank | (lzb_en & cur_lz);
  assign seg_hi  = dark ? 7'h00 : hex7(cur_nib);
  assign seg_pin = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + CW'(1);
      frame_done <= pre_tick & last;
      if (tick)
        idx <= last ? '0 : idx + IW'(1);
    end
  end

  // A load coinciding with the boundary bypasses pending entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data  <= '0;
      pend_blank <= '0;
      shad_data  <= '0;
      shad_blank <= '0;
      upd_pend   <= 1'b0;
    end else begin
      if (load) begin
        pend_data  <= data_in;
        pend_blank <= blank_mask;
      end
      if (wrap) begin
        upd_pend <= 1'b0;
        if (load) begin
          shad_data  <= data_in;
          shad_blank <= blank_mask;
        end else if (upd_pend) begin
          shad_data  <= pend_data;
          shad_blank <= pend_blank;
        end
      end else if (load) begin
        upd_pend <= 1'b1;
      end
    end
  end

  // Anodes go dark for the tick cycle so the old segments never ghost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else if (tick) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= seg_pin;
      an  <= AN_ACTIVE_LOW ? ~an_hot : an_hot;
    end
  end

`ifdef LED7SEG_SCAN_DP_EN
  logic [N_DIGITS-1:0] pend_dp;
  logic [N_DIGITS-1:0] shad_dp;
  logic                cur_dp;

  always_comb begin
    cur_dp = 1'b0;
    for (int k = 0; k < N_DIGITS; k++)
      if (idx == IW'(k))
        cur_dp = shad_dp[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dp <= '0;
      shad_dp <= '0;
      dp      <= SEG_ACTIVE_LOW;
    end else begin
      if (load)
        pend_dp <= dp_in;
      if (wrap) begin
        if (load)
          shad_dp <= dp_in;
        else if (upd_pend)
          shad_dp <= pend_dp;
      end
      if (tick)
        dp <= SEG_ACTIVE_LOW;
      else
        dp <= (cur_dp & ~dark) ^ SEG_ACTIVE_LOW;
    end
  end
`endif

endmodule

// File: tb/tb_led7seg_scan_driver.sv
// Directed bench for led7seg_scan_driver: N_DIGITS=4, CLK_DIV=4,
// active-low segments and anodes.
module tb_led7seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        load;
  logic [3:0]  blank_mask;
  logic        lzb_en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        upd_pend;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  led7seg_scan_driver #(
    .N_DIGITS(4),
    .CLK_DIV(4),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .load(load),
    .blank_mask(blank_mask),
    .lzb_en(lzb_en),
    .seg(seg),
    .an(an),
    .upd_pend(upd_pend),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Step to the next frame_done cycle; n = negedges waited.
  task automatic wait_frame(output int n);
    logic seen;
    seen = 1'b0;
    n    = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_timeout", seen, 1'b1);
  endtask

  // Called on a frame_done negedge; walks one full 16-cycle frame.
  task automatic check_frame(input logic ld,
                             input logic [15:0] d,
                             input logic [3:0] bm,
                             input logic [27:0] es,
                             input logic eu);
    logic [3:0] ea;
    int pos;
    int dg;
    if (ld) begin
      load       = 1'b1;
      data_in    = d;
      blank_mask = bm;
    end
    for (int s = 1; s <= 16; s++) begin
      @(negedge clk);
      load = 1'b0;
      if (s == 1)
        check("upd_after_bound", upd_pend, eu);
      pos = (s - 1) % 4;
      dg  = (s - 1) / 4;
      if (pos == 0) begin
        check("an_ghost", an, 4'hF);
        check("seg_ghost", seg, 7'h7F);
      end else begin
        ea = ~(4'b0001 << dg);
        check("an_digit", an, ea);
        check("seg_digit", seg, es[dg*7 +: 7]);
      end
      check("frame_done", frame_done, s == 16);
    end
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    data_in    = '0;
    load       = 1'b0;
    blank_mask = '0;
    lzb_en     = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_upd", upd_pend, 1'b0);
    check("rst_fd", frame_done, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_an", an, 4'hE);
    check("idle_seg", seg, 7'h40);

    // Normal pending path
    load    = 1'b1;
    data_in = 16'h1A3F;
    @(negedge clk);
    load = 1'b0;
    check("upd_set", upd_pend, 1'b1);
    wait_frame(n);
    check_frame(1'b0, 16'h0, 4'h0,
                {7'h79, 7'h08, 7'h30, 7'h0E}, 1'b0);

    // Tear-free mid-frame load
    repeat (6) @(negedge clk);
    load    = 1'b1;
    data_in = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    check("tear_upd", upd_pend, 1'b1);
    repeat (3) @(negedge clk);
    check("tear_an2", an, 4'hB);
    check("tear_seg2", seg, 7'h08);
    repeat (4) @(negedge clk);
    check("tear_an3", an, 4'h7);
    check("tear_seg3", seg, 7'h79);
    repeat (2) @(negedge clk);
    check("tear_fd", frame_done, 1'b1);
    check("tear_upd_hold", upd_pend, 1'b1);
    check_frame(1'b0, 16'h0, 4'h0,
                {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0);

    // Load exactly on the boundary cycle
    check_frame(1'b1, 16'h00FF, 4'h0,
                {7'h40, 7'h40, 7'h0E, 7'h0E}, 1'b0);

    // Leading-zero blanking and blank mask
    lzb_en = 1'b1;
    check_frame(1'b1, 16'h0050, 4'h0,
                {7'h7F, 7'h7F, 7'h12, 7'h40}, 1'b0);
    check_frame(1'b1, 16'h0000, 4'h0,
                {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0);
    check_frame(1'b1, 16'h0000, 4'h1,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 1'b0);

    // Async reset while digit 2 is lit, with data pending
    lzb_en     = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_an", an, 4'hB);
    load       = 1'b1;
    data_in    = 16'h9999;
    blank_mask = 4'h0;
    @(negedge clk);
    load = 1'b0;
    check("pre_rst_upd", upd_pend, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_an", an, 4'hF);
    check("async_seg", seg, 7'h7F);
    check("async_upd", upd_pend, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("restart_an", an, 4'hE);
    check("restart_seg", seg, 7'h40);
    wait_frame(n);
    check("restart_phase", n, 13);
    check_frame(1'b0, 16'h0, 4'h0,
                {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
